// File: rtl/video_pkg.sv
// Shared 720p timing constants and the signed screen-coordinate type used by
// video_timing and the game-object blocks.
package video_pkg;

    typedef logic signed [11:0] coord_t;

    localparam int COORD_MIN = -2048;
    localparam int COORD_MAX = 2047;

    localparam int HRES_720   = 1280;
    localparam int H_FP_720   = 110;
    localparam int H_SYNC_720 = 40;
    localparam int H_BP_720   = 220;

    localparam int VRES_720   = 720;
    localparam int V_FP_720   = 5;
    localparam int V_SYNC_720 = 5;
    localparam int V_BP_720   = 20;

    // True when both the blanking start and the last active coordinate fit coord_t.
    function automatic bit fits_coord(input int res, input int blank);
        return (res >= 1) && (blank >= 1) &&
               (res - 1 <= COORD_MAX) && (-blank >= COORD_MIN);
    endfunction

endpackage

// File: rtl/video_timing.sv
// Raster timing generator: signed pixel/line coordinates (negative in blanking),
// syncs, data enable, line/frame strobes and a completed-frame counter.
module video_timing
    import video_pkg::*;
#(
    parameter int HRES   = HRES_720,
    parameter int VRES   = VRES_720,
    parameter int H_FP   = H_FP_720,
    parameter int H_SYNC = H_SYNC_720,
    parameter int H_BP   = H_BP_720,
    parameter int V_FP   = V_FP_720,
    parameter int V_SYNC = V_SYNC_720,
    parameter int V_BP   = V_BP_720,
    parameter bit H_POL  = 1'b1,
    parameter bit V_POL  = 1'b1
) (
    input  logic        pixel_clk,
    input  logic        rst,
    output coord_t      hpos,
    output coord_t      vpos,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        fsync,
    output logic        lsync,
    output logic [15:0] frame
);

    localparam int H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int V_BLANK = V_FP + V_SYNC + V_BP;

    localparam coord_t H_START  = coord_t'(-H_BLANK);
    localparam coord_t H_LAST   = coord_t'(HRES - 1);
    localparam coord_t HS_FIRST = coord_t'(H_FP - H_BLANK);
    localparam coord_t HS_LAST  = coord_t'(H_FP + H_SYNC - 1 - H_BLANK);

    localparam coord_t V_START  = coord_t'(-V_BLANK);
    localparam coord_t V_LAST   = coord_t'(VRES - 1);
    localparam coord_t VS_FIRST = coord_t'(V_FP - V_BLANK);
    localparam coord_t VS_LAST  = coord_t'(V_FP + V_SYNC - 1 - V_BLANK);

    if (!fits_coord(HRES, H_BLANK) || !fits_coord(VRES, V_BLANK) ||
        H_SYNC < 1 || V_SYNC < 1) begin : g_bad_params
        $error("video_timing: line or frame timing does not fit the signed 12-bit coordinate range");
    end

    coord_t h_next;
    coord_t v_next;
    logic   h_wrap;
    logic   v_wrap;

    // Every output is registered from the next coordinates so all of them
    // describe the same pixel as hpos/vpos in the same cycle.
    always_comb begin
        h_wrap = (hpos == H_LAST);
        v_wrap = (vpos == V_LAST);
        h_next = h_wrap ? H_START : hpos + 12'sd1;
        v_next = vpos;
        if (h_wrap) begin
            v_next = v_wrap ? V_START : vpos + 12'sd1;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hpos  <= H_START;
            vpos  <= V_START;
            hsync <= ~H_POL;
            vsync <= ~V_POL;
            de    <= 1'b0;
            fsync <= 1'b0;
            lsync <= 1'b0;
            frame <= '0;
        end else begin
            hpos  <= h_next;
            vpos  <= v_next;
            hsync <= (h_next >= HS_FIRST && h_next <= HS_LAST) ? H_POL : ~H_POL;
            vsync <= (v_next >= VS_FIRST && v_next <= VS_LAST) ? V_POL : ~V_POL;
            de    <= (h_next >= 12'sd0) && (v_next >= 12'sd0);
            lsync <= h_wrap;
            fsync <= h_wrap && v_wrap;
            if (h_wrap && v_wrap) begin
                frame <= frame + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_video_timing.sv
// Self-checking bench for video_timing on a reduced raster, with an active-high
// and an active-low vsync instance checked against an arithmetic raster model.
module tb_video_timing;
    import video_pkg::*;

    localparam int T_HRES = 16, T_H_FP = 3, T_H_SYNC = 4, T_H_BP = 5;
    localparam int T_VRES = 8,  T_V_FP = 2, T_V_SYNC = 3, T_V_BP = 4;
    localparam int H_BLANK = T_H_FP + T_H_SYNC + T_H_BP;
    localparam int V_BLANK = T_V_FP + T_V_SYNC + T_V_BP;
    localparam int H0 = -H_BLANK;
    localparam int V0 = -V_BLANK;
    localparam int LINE  = T_HRES + H_BLANK;
    localparam int FRAME = LINE * (T_VRES + V_BLANK);

    typedef struct {
        int hpos; int vpos; bit hs; bit vs; bit de; bit ls; bit fs; int frame;
    } vid_t;

    typedef struct {
        bit   rst;
        int   ncyc;
        vid_t exp;
    } vec_t;

    logic        pixel_clk = 1'b0;
    logic        rst = 1'b1;
    coord_t      hpos_a, vpos_a, hpos_n, vpos_n;
    logic        hs_a, vs_a, de_a, fs_a, ls_a;
    logic        hs_n, vs_n, de_n, fs_n, ls_n;
    logic [15:0] frame_a, frame_n;

    int n_cmp = 0;
    int n_bad = 0;
    int t = 0;
    int foff = 0;

    always #5 pixel_clk = ~pixel_clk;

    video_timing #(
        .HRES(T_HRES), .VRES(T_VRES),
        .H_FP(T_H_FP), .H_SYNC(T_H_SYNC), .H_BP(T_H_BP),
        .V_FP(T_V_FP), .V_SYNC(T_V_SYNC), .V_BP(T_V_BP),
        .H_POL(1'b1), .V_POL(1'b1)
    ) dut (
        .pixel_clk(pixel_clk), .rst(rst), .hpos(hpos_a), .vpos(vpos_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .fsync(fs_a), .lsync(ls_a), .frame(frame_a)
    );

    video_timing #(
        .HRES(T_HRES), .VRES(T_VRES),
        .H_FP(T_H_FP), .H_SYNC(T_H_SYNC), .H_BP(T_H_BP),
        .V_FP(T_V_FP), .V_SYNC(T_V_SYNC), .V_BP(T_V_BP),
        .H_POL(1'b1), .V_POL(1'b0)
    ) dut_n (
        .pixel_clk(pixel_clk), .rst(rst), .hpos(hpos_n), .vpos(vpos_n),
        .hsync(hs_n), .vsync(vs_n), .de(de_n), .fsync(fs_n), .lsync(ls_n), .frame(frame_n)
    );

    // t = rising edges since reset was released; position within the frame is t mod FRAME.
    function automatic vid_t model(input int tt, input bit vpol, input int off);
        vid_t e;
        int p;
        p = tt % FRAME;
        e.hpos  = H0 + p % LINE;
        e.vpos  = V0 + p / LINE;
        e.hs    = (e.hpos >= H0 + T_H_FP) && (e.hpos < H0 + T_H_FP + T_H_SYNC);
        e.vs    = ((e.vpos >= V0 + T_V_FP) && (e.vpos < V0 + T_V_FP + T_V_SYNC)) ? vpol : !vpol;
        e.de    = (e.hpos >= 0) && (e.vpos >= 0);
        e.ls    = (tt > 0) && (p % LINE == 0);
        e.fs    = (tt > 0) && (p == 0);
        e.frame = (off + tt / FRAME) & 16'hFFFF;
        return e;
    endfunction

    function automatic vid_t samp_a();
        vid_t s;
        s.hpos = int'(hpos_a); s.vpos = int'(vpos_a);
        s.hs = hs_a; s.vs = vs_a; s.de = de_a; s.ls = ls_a; s.fs = fs_a;
        s.frame = int'(frame_a);
        return s;
    endfunction

    function automatic vid_t samp_n();
        vid_t s;
        s.hpos = int'(hpos_n); s.vpos = int'(vpos_n);
        s.hs = hs_n; s.vs = vs_n; s.de = de_n; s.ls = ls_n; s.fs = fs_n;
        s.frame = int'(frame_n);
        return s;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_vid(input string nm, input vid_t a, input vid_t e);
        n_cmp++;
        if (a.hpos != e.hpos || a.vpos != e.vpos || a.hs != e.hs || a.vs != e.vs ||
            a.de != e.de || a.ls != e.ls || a.fs != e.fs || a.frame != e.frame) begin
            n_bad++;
            $display("FAIL %s t=%0d: got h=%0d v=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b fr=%0d, expected h=%0d v=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b fr=%0d",
                     nm, t, a.hpos, a.vpos, a.hs, a.vs, a.de, a.ls, a.fs, a.frame,
                     e.hpos, e.vpos, e.hs, e.vs, e.de, e.ls, e.fs, e.frame);
        end
    endtask

    // One clock: drive rst, advance the model, sample 1 time unit after the edge.
    task automatic step(input bit r);
        rst = r;
        @(posedge pixel_clk);
        if (r) begin
            t = 0;
            foff = 0;
        end else begin
            t++;
        end
        #1;
        chk_vid("raster_pos", samp_a(), model(t, 1'b1, foff));
        chk_vid("raster_neg", samp_n(), model(t, 1'b0, 0));
    endtask

    vec_t vecs[16];

    initial begin
        int prev_l, prev_f, prev_fn, n_ls, n_fs, n_fs_n, n_de, n_hs, n_vs, n_vsn;
        int de_fh, de_fv, de_lh, de_lv, hs_h, vs_h, vs_v, vsn_h, vsn_v;
        bit found;

        vecs[0]  = '{1'b1,   2, '{-12, -9, 0, 0, 0, 0, 0, 0}};
        vecs[1]  = '{1'b0,   1, '{-11, -9, 0, 0, 0, 0, 0, 0}};
        vecs[2]  = '{1'b0,   2, '{ -9, -9, 1, 0, 0, 0, 0, 0}};
        vecs[3]  = '{1'b0,   3, '{ -6, -9, 1, 0, 0, 0, 0, 0}};
        vecs[4]  = '{1'b0,   1, '{ -5, -9, 0, 0, 0, 0, 0, 0}};
        vecs[5]  = '{1'b0,  20, '{ 15, -9, 0, 0, 0, 0, 0, 0}};
        vecs[6]  = '{1'b0,   1, '{-12, -8, 0, 0, 0, 1, 0, 0}};
        vecs[7]  = '{1'b0,   1, '{-11, -8, 0, 0, 0, 0, 0, 0}};
        vecs[8]  = '{1'b0,  27, '{-12, -7, 0, 1, 0, 1, 0, 0}};
        vecs[9]  = '{1'b0, 208, '{  0,  0, 0, 0, 1, 0, 0, 0}};
        vecs[10] = '{1'b0,  15, '{ 15,  0, 0, 0, 1, 0, 0, 0}};
        vecs[11] = '{1'b0,   1, '{-12,  1, 0, 0, 0, 1, 0, 0}};
        vecs[12] = '{1'b0, 195, '{ 15,  7, 0, 0, 1, 0, 0, 0}};
        vecs[13] = '{1'b0,   1, '{-12, -9, 0, 0, 0, 1, 1, 1}};
        vecs[14] = '{1'b0,   1, '{-11, -9, 0, 0, 0, 0, 0, 1}};
        vecs[15] = '{1'b1,   1, '{-12, -9, 0, 0, 0, 0, 0, 0}};

        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < vecs[i].ncyc; c++) step(vecs[i].rst);
            chk_vid($sformatf("vec%0d", i), samp_a(), vecs[i].exp);
        end

        // Periods, widths and window placement over two frames from release.
        step(1);
        prev_l = -1; prev_f = -1; prev_fn = -1;
        n_ls = 0; n_fs = 0; n_fs_n = 0; n_de = 0; n_hs = 0; n_vs = 0; n_vsn = 0;
        de_fh = 99; de_fv = 99; de_lh = 99; de_lv = 99;
        hs_h = 99; vs_h = 99; vs_v = 99; vsn_h = 99; vsn_v = 99;
        for (int k = 1; k <= 2 * FRAME; k++) begin
            step(0);
            if (ls_a) begin
                n_ls++;
                if (prev_l >= 0) chk("lsync_period", k - prev_l, LINE);
                prev_l = k;
            end
            if (fs_a) begin
                n_fs++;
                if (prev_f >= 0) chk("fsync_period", k - prev_f, FRAME);
                prev_f = k;
            end
            if (fs_n) begin
                n_fs_n++;
                if (prev_fn >= 0) chk("fsync_period_vpol0", k - prev_fn, FRAME);
                prev_fn = k;
            end
            if (k < LINE && hs_a) begin
                if (n_hs == 0) hs_h = int'(hpos_a);
                n_hs++;
            end
            if (k <= FRAME) begin
                if (de_a) begin
                    if (n_de == 0) begin de_fh = int'(hpos_a); de_fv = int'(vpos_a); end
                    de_lh = int'(hpos_a); de_lv = int'(vpos_a);
                    n_de++;
                end
                if (vs_a) begin
                    if (n_vs == 0) begin vs_h = int'(hpos_a); vs_v = int'(vpos_a); end
                    n_vs++;
                end
                if (!vs_n) begin
                    if (n_vsn == 0) begin vsn_h = int'(hpos_n); vsn_v = int'(vpos_n); end
                    n_vsn++;
                end
            end
        end
        chk("lsync_count", n_ls, 2 * FRAME / LINE);
        chk("fsync_count", n_fs, 2);
        chk("fsync_count_vpol0", n_fs_n, 2);
        chk("de_count", n_de, T_HRES * T_VRES);
        chk("de_first_h", de_fh, 0);
        chk("de_first_v", de_fv, 0);
        chk("de_last_h", de_lh, T_HRES - 1);
        chk("de_last_v", de_lv, T_VRES - 1);
        chk("hsync_width", n_hs, T_H_SYNC);
        chk("hsync_start_h", hs_h, H0 + T_H_FP);
        chk("vsync_cycles", n_vs, T_V_SYNC * LINE);
        chk("vsync_start_v", vs_v, V0 + T_V_FP);
        chk("vsync_start_h", vs_h, H0);
        chk("vsync_low_cycles_vpol0", n_vsn, T_V_SYNC * LINE);
        chk("vsync_low_start_v_vpol0", vsn_v, V0 + T_V_FP);
        chk("vsync_low_start_h_vpol0", vsn_h, H0);

        // Reset in the middle of the active area, held three cycles.
        found = 1'b0;
        for (int i = 0; i < FRAME + LINE && !found; i++) begin
            step(0);
            if (hpos_a == 12'sd5 && vpos_a == 12'sd3) found = 1'b1;
        end
        chk("reach_mid_frame", int'(found), 1);
        step(1);
        chk("midrst_hpos", int'(hpos_a), H0);
        chk("midrst_de", int'(de_a), 0);
        step(1);
        step(1);
        step(0);
        chk("restart_hpos", int'(hpos_a), H0 + 1);
        chk("restart_vpos", int'(vpos_a), V0);

        // Frame counter roll-over from 0xFFFF, coincident with fsync.
        for (int i = 0; i < 100; i++) step(0);
        force dut.frame = 16'hFFFF;
        foff = (16'hFFFF - t / FRAME) & 16'hFFFF;
        step(0);
        release dut.frame;
        #1;
        chk("frame_forced", int'(frame_a), 16'hFFFF);
        found = 1'b0;
        for (int i = 0; i < FRAME && !found; i++) begin
            step(0);
            if (fs_a) found = 1'b1;
        end
        chk("reach_frame_wrap", int'(found), 1);
        chk("frame_wrapped", int'(frame_a), 0);
        chk("wrap_hpos", int'(hpos_a), H0);
        chk("wrap_vpos", int'(vpos_a), V0);

        // Random reset pulses; every cycle is checked against the model inside step().
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
